// File: rtl/aimbot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aimbot_pkg
// Brief    : Shared scheduler state encoding, row width and camera ids.
// Revision : 1.0
// ============================================================================
package aimbot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    localparam int   ROW_W = 10;
    localparam logic CAM1  = 1'b0;
    localparam logic CAM2  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : timeout_counter
// Brief    : Loadable down-counter; o_expired is high on the last counted cycle.
// Revision : 1.0
// ============================================================================
module timeout_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A value of N loaded on entry expires in the Nth cycle of the state.
    assign o_expired = (r_cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/udp_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : udp_line_scheduler
// Brief    : Paces camera lines into UDP packets (LOAD/SEND/GAP) with timeouts.
// Revision : 1.0
// ============================================================================
module udp_line_scheduler
    import aimbot_pkg::*;
#(
    parameter int V_ACT      = 720,
    parameter int GAP_CYCLES = 64,
    parameter int FRAME_DIV  = 1,
    parameter int TIMEOUT    = 16384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_start,
    input  logic             udp_connected,
    input  logic             lb_valid,
    input  logic             udp_done,
    input  logic             clr_err,
    output logic             lb_trig,
    output logic             udp_trig,
    output logic [ROW_W-1:0] cur_row,
    output logic             cur_cam,
    output logic             busy,
    output logic             frame_drop,
    output logic             timeout_err,
    output logic [15:0]      frame_cnt
);

    localparam int C_CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [C_CNT_W-1:0] C_TIMEOUT  = C_CNT_W'(TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_GAP      = C_CNT_W'(GAP_CYCLES);
    localparam logic [ROW_W-1:0]   C_LAST_ROW = ROW_W'(V_ACT - 1);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(FRAME_DIV - 1);

    sched_state_t       r_state, w_next;
    logic [C_DIV_W-1:0] r_div, w_div_next;
    logic [C_CNT_W-1:0] w_load_val;
    logic               w_load, w_expired;
    logic               w_lb_trig, w_udp_trig, w_drop, w_timeout, w_frame_done, w_advance;
    logic               r_lb_trig, r_udp_trig, r_busy, r_drop, r_err, r_cam;
    logic [ROW_W-1:0]   r_row;
    logic [15:0]        r_frame_cnt;

    timeout_counter #(.WIDTH(C_CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_next       = r_state;
        w_div_next   = r_div;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_lb_trig    = 1'b0;
        w_udp_trig   = 1'b0;
        w_drop       = 1'b0;
        w_timeout    = 1'b0;
        w_frame_done = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    if (en && udp_connected) begin
                        w_div_next = (r_div == C_DIV_LAST) ? '0 : r_div + 1'b1;
                        if (r_div == '0) begin
                            w_next     = LOAD;
                            w_lb_trig  = 1'b1;
                            w_load     = 1'b1;
                            w_load_val = C_TIMEOUT;
                        end
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            LOAD: begin
                // lb_valid coinciding with the trigger is stale and ignored.
                if (lb_valid && !r_lb_trig) begin
                    w_next     = SEND;
                    w_udp_trig = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = C_TIMEOUT;
                end else if (w_expired) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            SEND: begin
                if (udp_done && !r_udp_trig) begin
                    w_next     = GAP;
                    w_load     = 1'b1;
                    w_load_val = C_GAP;
                end else if (w_expired) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            GAP: begin
                if (w_expired) begin
                    if (r_cam == CAM2 && r_row == C_LAST_ROW) begin
                        w_next       = IDLE;
                        w_frame_done = 1'b1;
                    end else begin
                        w_next     = LOAD;
                        w_advance  = 1'b1;
                        w_lb_trig  = 1'b1;
                        w_load     = 1'b1;
                        w_load_val = C_TIMEOUT;
                    end
                end
            end
            default: w_next = IDLE;
        endcase

        if (r_state != IDLE) begin
            w_drop = frame_start;
            // Link loss overrides any handshake, timeout or frame completion.
            if (!udp_connected) begin
                w_next       = IDLE;
                w_lb_trig    = 1'b0;
                w_udp_trig   = 1'b0;
                w_timeout    = 1'b0;
                w_frame_done = 1'b0;
                w_advance    = 1'b0;
            end
            if (w_next == IDLE) begin
                w_load     = 1'b1;
                w_load_val = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_lb_trig   <= 1'b0;
            r_udp_trig  <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
            r_err       <= 1'b0;
            r_cam       <= CAM1;
            r_row       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_div      <= w_div_next;
            r_lb_trig  <= w_lb_trig;
            r_udp_trig <= w_udp_trig;
            r_busy     <= (w_next != IDLE);
            r_drop     <= w_drop;
            if (w_next == IDLE) begin
                r_row <= '0;
                r_cam <= CAM1;
            end else if (w_advance) begin
                if (r_cam == CAM1) begin
                    r_cam <= CAM2;
                end else begin
                    r_cam <= CAM1;
                    r_row <= r_row + 1'b1;
                end
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign lb_trig     = r_lb_trig;
    assign udp_trig    = r_udp_trig;
    assign cur_row     = r_row;
    assign cur_cam     = r_cam;
    assign busy        = r_busy;
    assign frame_drop  = r_drop;
    assign timeout_err = r_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_line_scheduler
// Brief    : Randomised-handshake bench for udp_line_scheduler with a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_udp_line_scheduler;

    localparam int V  = 4;
    localparam int G  = 3;
    localparam int FD = 3;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst, en, frame_start, udp_connected, lb_valid, udp_done, clr_err;
    logic        lb_trig, udp_trig, cur_cam, busy, frame_drop, timeout_err;
    logic [9:0]  cur_row;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int n_lb = 0, n_udp = 0, n_drop = 0, wide = 0;
    logic p_lb = 1'b0, p_udp = 1'b0, p_drop = 1'b0;
    int div_m = 0;
    int fc_m  = 0;

    always #5 clk = ~clk;

    udp_line_scheduler #(
        .V_ACT(V), .GAP_CYCLES(G), .FRAME_DIV(FD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
        .udp_connected(udp_connected), .lb_valid(lb_valid), .udp_done(udp_done),
        .clr_err(clr_err), .lb_trig(lb_trig), .udp_trig(udp_trig),
        .cur_row(cur_row), .cur_cam(cur_cam), .busy(busy), .frame_drop(frame_drop),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    // Pulse counters and single-cycle width monitor.
    always @(negedge clk) begin
        if (lb_trig)    n_lb   <= n_lb + 1;
        if (udp_trig)   n_udp  <= n_udp + 1;
        if (frame_drop) n_drop <= n_drop + 1;
        if ((lb_trig && p_lb) || (udp_trig && p_udp) || (frame_drop && p_drop)) wide <= wide + 1;
        p_lb   <= lb_trig;
        p_udp  <= udp_trig;
        p_drop <= frame_drop;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sig(input int s);
        return (s == 0) ? lb_trig : (s == 1) ? udp_trig : busy;
    endfunction

    task automatic wait_sig(input int s, input int limit, output int n);
        n = 0;
        while (!sig(s) && n < limit) begin
            tick();
            n++;
        end
        if (!sig(s)) check($sformatf("wait_sig%0d", s), sig(s), 1);
    endtask

    // Pulses frame_start until the decimation model predicts an accepted frame.
    task automatic start_frame();
        for (int i = 0; i <= FD; i++) begin
            logic acc;
            acc   = (div_m == 0);
            div_m = (div_m + 1) % FD;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            if (acc) return;
            check("skip_busy", busy, 0);
            repeat (3) tick();
        end
    endtask

    // Packet k carries row k/2, camera k%2; responder delays are random.
    task automatic do_packets(input int first, input int last, input int inject_k);
        int n, d;
        for (int k = first; k <= last; k++) begin
            wait_sig(0, 200, n);
            check("lb_gap", n, (k == first) ? 0 : G);
            check("cur_row", cur_row, k / 2);
            check("cur_cam", cur_cam, k % 2);
            d = $urandom_range(1, 5);
            for (int i = 0; i < d; i++) begin
                if (k == inject_k && i == 0) begin
                    frame_start = 1'b1;
                    en = 1'b0;
                end else begin
                    frame_start = 1'b0;
                end
                tick();
            end
            frame_start = 1'b0;
            lb_valid = 1'b1;
            tick();
            lb_valid = 1'b0;
            wait_sig(1, 200, n);
            check("udp_lat", n, 0);
            d = $urandom_range(1, 12);
            repeat (d) tick();
            udp_done = 1'b1;
            tick();
            udp_done = 1'b0;
        end
    endtask

    task automatic finish_frame();
        repeat (G - 1) tick();
        check("busy_in_last_gap", busy, 1);
        tick();
        fc_m = (fc_m + 1) & 16'hFFFF;
        check("busy_after_frame", busy, 0);
        check("frame_cnt", frame_cnt, fc_m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, s_lb, s_udp, s_drop;
        rst = 1'b1; en = 1'b1; udp_connected = 1'b1;
        frame_start = 1'b0; lb_valid = 1'b0; udp_done = 1'b0; clr_err = 1'b0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_row", cur_row, 0);
        check("rst_cam", cur_cam, 0);
        check("rst_trig", {lb_trig, udp_trig, frame_drop}, 0);
        check("rst_err", timeout_err, 0);
        check("rst_fcnt", frame_cnt, 0);
        rst = 1'b0;
        tick();

        // Full frame: 8 packets in row/camera order.
        #1; s_lb = n_lb; s_udp = n_udp;
        start_frame();
        do_packets(0, 2 * V - 1, -1);
        finish_frame();
        #1;
        check("frame_lb_cnt", n_lb - s_lb, 2 * V);
        check("frame_udp_cnt", n_udp - s_udp, 2 * V);

        // Decimation: only pulses 1, 4 and 7 start a transfer.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        div_m = 0; fc_m = 0;
        #1; s_lb = n_lb; s_drop = n_drop;
        for (int p = 1; p <= 7; p++) begin
            logic exp_start;
            exp_start = ((p - 1) % FD == 0);
            div_m = (div_m + 1) % FD;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check($sformatf("div_start_p%0d", p), lb_trig, exp_start);
            if (exp_start) begin
                do_packets(0, 2 * V - 1, -1);
                finish_frame();
            end
            repeat (5) tick();
        end
        #1;
        check("div_fcnt", frame_cnt, 3);
        check("div_lb_cnt", n_lb - s_lb, 3 * 2 * V);
        check("div_no_drop", n_drop - s_drop, 0);

        // LOAD timeout: lb_valid never comes.
        start_frame();
        check("to_trig", lb_trig, 1);
        repeat (TO - 1) tick();
        check("to_err_early", timeout_err, 0);
        check("to_busy_early", busy, 1);
        tick();
        check("to_err", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_fcnt", frame_cnt, fc_m);
        repeat (3) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("clr_err", timeout_err, 0);

        // Disconnect during SEND of row 2.
        start_frame();
        do_packets(0, 3, -1);
        wait_sig(0, 200, n);
        check("dc_gap", n, G);
        check("dc_row", cur_row, 2);
        repeat ($urandom_range(1, 4)) tick();
        lb_valid = 1'b1; tick(); lb_valid = 1'b0;
        wait_sig(1, 200, n);
        udp_connected = 1'b0;
        tick();
        check("dc_busy", busy, 0);
        check("dc_row_clr", cur_row, 0);
        udp_connected = 1'b1;
        #1; s_lb = n_lb; s_udp = n_udp;
        repeat (20) tick();
        #1;
        check("dc_no_trig", (n_lb - s_lb) + (n_udp - s_udp), 0);
        check("dc_fcnt", frame_cnt, fc_m);
        check("dc_err", timeout_err, 0);

        // frame_start while busy (with en dropped mid-frame), then with en=0 in IDLE.
        #1; s_drop = n_drop;
        start_frame();
        do_packets(0, 2 * V - 1, 3);
        finish_frame();
        #1;
        check("drop_busy", n_drop - s_drop, 1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("drop_en0_busy", busy, 0);
        tick();
        #1;
        check("drop_en0", n_drop - s_drop, 2);
        en = 1'b1;

        // Asynchronous reset while in GAP.
        start_frame();
        do_packets(0, 0, -1);
        tick();
        check("gap_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_row_cam", {cur_row, cur_cam}, 0);
        check("arst_fcnt", frame_cnt, 0);
        check("arst_flags", {lb_trig, udp_trig, frame_drop, timeout_err}, 0);
        tick(); tick();
        rst = 1'b0;
        div_m = 0; fc_m = 0;
        #1; s_lb = n_lb; s_udp = n_udp;
        repeat (5) tick();
        #1;
        check("post_rst_no_trig", (n_lb - s_lb) + (n_udp - s_udp), 0);
        check("post_rst_busy", busy, 0);

        check("pulse_width", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_line_scheduler.md
Name: udp_line_scheduler

Overview:
- Sequences the dual-camera line buffer and the UDP transmitter in the rgmii_clk domain: one camera line per UDP packet, alternating cam 0/cam 1 per row, rows 0..V_ACT-1, started on frame start.
- Drives the line buffer trigger and the UDP trigger, waits on their handshakes, inserts an inter-packet gap, and supervises with timeouts.
- Decimates frames so link bandwidth is never exceeded.

Parameters:
- V_ACT, 720, rows per frame; row counter range 0..V_ACT-1.
- GAP_CYCLES, 64, idle clk cycles between udp_done and the next lb_trig; minimum 1.
- FRAME_DIV, 1, transmit one frame out of every FRAME_DIV frame_start pulses; minimum 1.
- TIMEOUT, 16384, maximum clk cycles spent in LOAD or SEND before aborting.

Ports:
- clk  input  1  rgmii_clk domain clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  level; 0 blocks new frames; a frame in progress completes.
- frame_start  input  1  single-cycle pulse, already synchronised to clk.
- udp_connected  input  1  link/ARP resolved; 0 aborts the transfer.
- lb_valid  input  1  line buffer has the requested line ready to read.
- udp_done  input  1  single-cycle pulse, packet fully transmitted.
- clr_err  input  1  pulse; clears timeout_err.
- lb_trig  output  1  single-cycle pulse: load next line (cur_cam, cur_row).
- udp_trig  output  1  single-cycle pulse: start packet transmission.
- cur_row  output  10  row being transferred.
- cur_cam  output  1  camera being transferred, 0 = cam1, 1 = cam2.
- busy  output  1  high in every state except IDLE.
- frame_drop  output  1  single-cycle pulse: frame_start ignored (busy, en=0, or disconnected).
- timeout_err  output  1  sticky: a LOAD/SEND timeout occurred.
- frame_cnt  output  16  frames fully transferred; wraps 0xFFFF->0.

Behaviour:
- Reset: all outputs 0; state IDLE; decimation counter 0; gap/timeout counters 0.
- Outputs are registered. lb_trig and udp_trig are high exactly one cycle.
- IDLE, on frame_start:
  - If en and udp_connected: advance the decimation counter mod FRAME_DIV.
  - If the counter was 0 before advancing: cur_row<=0, cur_cam<=0, go to LOAD.
  - Otherwise the frame is skipped silently.
  - If en=0 or udp_connected=0: pulse frame_drop.
- LOAD: lb_trig pulses on the first cycle after entry. Wait for lb_valid. lb_valid sampled on the same cycle as the lb_trig pulse is ignored. On lb_valid go to SEND.
- SEND: udp_trig pulses on the first cycle after entry. Wait for udp_done (not sampled on the trigger cycle). On udp_done go to GAP.
- GAP: count GAP_CYCLES cycles, then advance:
  - If cur_cam=0: cur_cam<=1.
  - Else cur_cam<=0 and cur_row++.
  - If the completed packet was cur_cam=1 with cur_row=V_ACT-1: frame_cnt++ and go to IDLE; cur_row/cur_cam return to 0.
  - Otherwise go to LOAD.
- Timeout: a counter resets on entering LOAD or SEND. When TIMEOUT cycles elapse without the awaited handshake: timeout_err<=1, go to IDLE, frame not counted.
- timeout_err clears only on clr_err or rst. If a new timeout and clr_err occur in the same cycle, the set wins.
- Disconnect: udp_connected=0 in any non-IDLE state forces IDLE next cycle; row/cam cleared, no frame_cnt increment, no error flag.
- frame_start while busy: pulse frame_drop; the transfer continues unaffected.
- en deasserted mid-frame does not abort.
- Simultaneous frame_start and return-to-IDLE cycle: the frame_start is dropped (frame_drop pulses).
- Asynchronous rst mid-transfer: immediate return to reset values; no trigger pulse is emitted during or right after reset.

Decomposition:
- Shared package aimbot_pkg:
  - state enum sched_state_t {IDLE, LOAD, SEND, GAP}.
  - ROW_W=10 constant.
  - CAM1/CAM2 id constants.
- One sub-module is natural: timeout_counter. It is a loadable down-counter with a start/clear input and an expiry pulse output, reused for both GAP and TIMEOUT timing.

Test Plan:
- Full frame, V_ACT=4, GAP_CYCLES=3, lb_valid 2 cycles after each lb_trig, udp_done 10 cycles after each udp_trig -> 8 lb_trig/udp_trig pairs, (row,cam) sequence (0,0)(0,1)(1,0)…(3,1), frame_cnt=1, busy low afterwards; every gap measured at exactly 3 cycles.
- FRAME_DIV=3, 7 frame_start pulses spaced past frame duration -> transfers start on pulses 1, 4 and 7 only, frame_cnt=3, no frame_drop.
- lb_valid never asserted, TIMEOUT=100 -> timeout_err set 100 cycles after lb_trig, state IDLE, frame_cnt unchanged; clr_err pulse -> timeout_err=0.
- udp_connected dropped during SEND of row 2 -> IDLE next cycle, cur_row=0, no udp_trig afterwards, frame_cnt unchanged, timeout_err=0.
- frame_start pulsed mid-transfer, and with en=0 in IDLE -> frame_drop pulses once each; the active transfer completes with frame_cnt+1.
- rst asserted during GAP -> all outputs 0 asynchronously; no trigger pulse for 5 cycles after release without a new frame_start.
